// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared field layout and helpers for the write-back bundle
package wb_pkg;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 64;
    localparam int BUNDLE_W = 69;
    localparam int WE_BIT   = 68;
    localparam int ADDR_HI  = 67;
    localparam int ADDR_LO  = 64;
    localparam int NUM_REGS = 16;

    typedef logic [BUNDLE_W-1:0] bundle_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_fields_t;

    function automatic bundle_t pack_bundle(input logic we, input logic [ADDR_W-1:0] addr,
                                            input logic [DATA_W-1:0] data);
        return {we, addr, data};
    endfunction

    function automatic wb_fields_t unpack_bundle(input bundle_t b);
        wb_fields_t f;
        f.we   = b[WE_BIT];
        f.addr = b[ADDR_HI:ADDR_LO];
        f.data = b[DATA_W-1:0];
        return f;
    endfunction
endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - per-requester bundle FIFO exposing per-entry addresses for hazard tracking
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  bundle_t                        push_data,
    input  logic                           pop,
    output bundle_t                        head,
    output logic                           full,
    output logic                           empty,
    output logic [DEPTH-1:0]               entry_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]   entry_addr
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][BUNDLE_W-1:0] mem;
    logic [PW-1:0]                  rd_ptr;
    logic [PW-1:0]                  wr_ptr;
    logic [PW:0]                    count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic [PW-1:0] off;
        assign off            = PW'(i) - rd_ptr;
        assign entry_valid[i] = ({1'b0, off} < count);
        assign entry_addr[i]  = mem[i][ADDR_HI:ADDR_LO];
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin scheduler for the single register-file write port
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  bundle_t             req0_bundle,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  bundle_t             req1_bundle,
    output bundle_t             wb_bundle,
    output logic [1:0]          grant,
    output logic [NUM_REGS-1:0] busy_regs
);
    bundle_t                     head0, head1;
    logic                        full0, full1, empty0, empty1;
    logic                        push0, push1, pop0, pop1;
    logic                        any_head, sel, rr;
    logic [DEPTH-1:0]            ev0, ev1;
    logic [DEPTH-1:0][ADDR_W-1:0] ea0, ea1;
    wb_fields_t                  wb_f;

    assign req0_ready = ~full0;
    assign req1_ready = ~full1;

    // Non-writes are handshaken like any request but never occupy a slot.
    assign push0 = req0_valid & req0_ready & req0_bundle[WE_BIT];
    assign push1 = req1_valid & req1_ready & req1_bundle[WE_BIT];

    wb_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk(clk), .rst(rst), .push(push0), .push_data(req0_bundle), .pop(pop0),
        .head(head0), .full(full0), .empty(empty0), .entry_valid(ev0), .entry_addr(ea0)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .rst(rst), .push(push1), .push_data(req1_bundle), .pop(pop1),
        .head(head1), .full(full1), .empty(empty1), .entry_valid(ev1), .entry_addr(ea1)
    );

    always_comb begin
        any_head = ~empty0 | ~empty1;
        sel      = (~empty0 & ~empty1) ? rr : empty0;
        pop0     = ~empty0 & ~sel;
        pop1     = ~empty1 & sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_bundle <= '0;
            grant     <= 2'b00;
            rr        <= 1'b0;
        end else if (any_head) begin
            wb_bundle <= sel ? head1 : head0;
            grant     <= sel ? 2'b10 : 2'b01;
            rr        <= ~sel;
        end else begin
            wb_bundle <= '0;
            grant     <= 2'b00;
        end
    end

    assign wb_f = unpack_bundle(wb_bundle);

    always_comb begin
        busy_regs = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ev0[i]) busy_regs[ea0[i]] = 1'b1;
            if (ev1[i]) busy_regs[ea1[i]] = 1'b1;
        end
        if (wb_f.we) busy_regs[wb_f.addr] = 1'b1;
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - randomized and directed bench against a queue-based reference model
module tb_wb_port_arbiter;
    import wb_pkg::*;

    localparam int DEPTH = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                req0_valid = 1'b0, req1_valid = 1'b0;
    logic                req0_ready, req1_ready;
    bundle_t             req0_bundle = '0, req1_bundle = '0;
    bundle_t             wb_bundle;
    logic [1:0]          grant;
    logic [NUM_REGS-1:0] busy_regs;

    int total = 0;
    int bad   = 0;

    // Reference model: two plain queues, a turn bit and the value on the port.
    bundle_t    q0[$];
    bundle_t    q1[$];
    bit         m_rr;
    bundle_t    m_wb;
    logic [1:0] m_grant;
    bit         m_acc0, m_acc1;

    wb_port_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_bundle(req0_bundle),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_bundle(req1_bundle),
        .wb_bundle(wb_bundle), .grant(grant), .busy_regs(busy_regs)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [68:0] obs, input logic [68:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_rr    = 1'b0;
        m_wb    = '0;
        m_grant = 2'b00;
        m_acc0  = 1'b0;
        m_acc1  = 1'b0;
    endtask

    task automatic model_step();
        int g;
        if (rst) return;
        m_acc0 = req0_valid && (q0.size() < DEPTH);
        m_acc1 = req1_valid && (q1.size() < DEPTH);
        if (q0.size() > 0 && q1.size() > 0) g = int'(m_rr);
        else if (q0.size() > 0)             g = 0;
        else if (q1.size() > 0)             g = 1;
        else                                g = -1;
        if (g == 0)      begin m_wb = q0.pop_front(); m_grant = 2'b01; m_rr = 1'b1; end
        else if (g == 1) begin m_wb = q1.pop_front(); m_grant = 2'b10; m_rr = 1'b0; end
        else             begin m_wb = '0;             m_grant = 2'b00; end
        if (m_acc0 && req0_bundle[WE_BIT]) q0.push_back(req0_bundle);
        if (m_acc1 && req1_bundle[WE_BIT]) q1.push_back(req1_bundle);
    endtask

    function automatic logic [NUM_REGS-1:0] model_busy();
        logic [NUM_REGS-1:0] b = '0;
        foreach (q0[i]) b[q0[i][ADDR_HI:ADDR_LO]] = 1'b1;
        foreach (q1[i]) b[q1[i][ADDR_HI:ADDR_LO]] = 1'b1;
        if (m_wb[WE_BIT]) b[m_wb[ADDR_HI:ADDR_LO]] = 1'b1;
        return b;
    endfunction

    task automatic check_model();
        check_val("wb_bundle", wb_bundle, m_wb);
        check_val("grant", grant, m_grant);
        check_val("busy_regs", busy_regs, model_busy());
        check_val("req0_ready", req0_ready, q0.size() < DEPTH);
        check_val("req1_ready", req1_ready, q1.size() < DEPTH);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_bundle = '0;
        req1_bundle = '0;
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_wb"}, wb_bundle, '0);
        check_val({tag, "_grant"}, grant, 2'b00);
        check_val({tag, "_busy"}, busy_regs, 16'h0000);
        check_val({tag, "_rdy0"}, req0_ready, 1'b1);
        check_val({tag, "_rdy1"}, req1_ready, 1'b1);
    endtask

    // Assert reset between edges and check outputs clear before any clock edge.
    task automatic reset_mid(input string tag);
        @(posedge clk);
        #2;
        rst = 1'b1;
        idle_inputs();
        model_reset();
        #1;
        check_reset_values(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int got1[$];
        bit saw_low;
        int v1, d0, n;

        model_reset();
        #1;
        check_reset_values("rst_init");
        @(negedge clk);
        rst = 1'b0;

        // Single write, no contention.
        req0_valid = 1'b1;
        req0_bundle = pack_bundle(1'b1, 4'd6, 64'd50);
        tick();
        idle_inputs();
        check_val("single_n_busy", busy_regs, 16'h0040);
        check_val("single_n_wb", wb_bundle, '0);
        tick();
        check_val("single_n1_wb", wb_bundle, pack_bundle(1'b1, 4'd6, 64'd50));
        check_val("single_n1_grant", grant, 2'b01);
        check_val("single_n1_busy", busy_regs, 16'h0040);
        tick();
        check_val("single_n2_wb", wb_bundle, '0);
        check_val("single_n2_busy", busy_regs, 16'h0000);

        // Contention from a fresh rr = 0.
        reset_mid("rst_mid");
        req0_valid = 1'b1; req0_bundle = pack_bundle(1'b1, 4'd3, 64'd25);
        req1_valid = 1'b1; req1_bundle = pack_bundle(1'b1, 4'd5, 64'd7);
        tick();
        idle_inputs();
        check_val("cont_busy0", busy_regs, 16'h0028);
        tick();
        check_val("cont_first", wb_bundle, pack_bundle(1'b1, 4'd3, 64'd25));
        check_val("cont_grant0", grant, 2'b01);
        check_val("cont_busy1", busy_regs, 16'h0028);
        tick();
        check_val("cont_second", wb_bundle, pack_bundle(1'b1, 4'd5, 64'd7));
        check_val("cont_grant1", grant, 2'b10);
        check_val("cont_busy2", busy_regs, 16'h0020);
        tick();
        check_val("cont_busy3", busy_regs, 16'h0000);

        // No-write request is accepted but never issued.
        req0_valid = 1'b1;
        req0_bundle = pack_bundle(1'b0, 4'd9, 64'hFF);
        check_val("nowr_ready", req0_ready, 1'b1);
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            check_val("nowr_we", wb_bundle[WE_BIT], 1'b0);
            check_val("nowr_busy9", busy_regs[9], 1'b0);
            tick();
        end

        // Backpressure: req1 holds values 1..5 to r2 while req0 streams.
        v1 = 1; d0 = 1000; saw_low = 1'b0; n = 0;
        while (got1.size() < 5 && n < 60) begin
            req0_valid = 1'b1; req0_bundle = pack_bundle(1'b1, 4'd3, 64'(d0));
            req1_valid = (v1 <= 5); req1_bundle = pack_bundle(1'b1, 4'd2, 64'(v1));
            tick();
            if (m_acc0) d0++;
            if (m_acc1 && v1 <= 5) v1++;
            if (!req1_ready) saw_low = 1'b1;
            if (grant == 2'b10) got1.push_back(int'(wb_bundle[31:0]));
            n++;
        end
        idle_inputs();
        check_val("bp_ready_drop", saw_low, 1'b1);
        check_val("bp_count", got1.size(), 5);
        foreach (got1[i]) check_val("bp_order", got1[i], i + 1);
        for (int i = 0; i < 4; i++) tick();

        // Reset while busy: 3 queued plus one on the port.
        req0_valid = 1'b1; req0_bundle = pack_bundle(1'b1, 4'd1, 64'd11);
        req1_valid = 1'b1; req1_bundle = pack_bundle(1'b1, 4'd4, 64'd44);
        tick();
        req0_bundle = pack_bundle(1'b1, 4'd7, 64'd77);
        req1_bundle = pack_bundle(1'b1, 4'd8, 64'd88);
        tick();
        idle_inputs();
        check_val("rb_pre_busy", busy_regs, 16'h0192);
        check_val("rb_pre_we", wb_bundle[WE_BIT], 1'b1);
        reset_mid("rst_busy");
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("rb_no_stale", wb_bundle, '0);
        end

        // Randomized traffic with occasional mid-cycle resets.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(99) == 0) begin
                reset_mid("rst_rand");
            end else begin
                req0_valid = ($urandom_range(99) < 60);
                req1_valid = ($urandom_range(99) < 60);
                req0_bundle = pack_bundle($urandom_range(99) < 85, 4'($urandom),
                                          {$urandom, $urandom});
                req1_bundle = pack_bundle($urandom_range(99) < 85, 4'($urandom),
                                          {$urandom, $urandom});
                tick();
            end
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbiter and scheduler for the single register-file write port. It accepts write-back requests from two pipeline sources: requester 0 (load/memory path) and requester 1 (ALU path). Each source has its own small FIFO, and the block grants the port round-robin. It drives the 69-bit write-back bundle consumed by `register_write`, one write per cycle. It also exports a pending-write scoreboard so the issue stage can detect hazards.

## Interface
Parameters:
- `DEPTH`, 2: entries per requester FIFO; must be a power of 2 and at least 2.

Ports:
- `clk`, in, 1: single clock; all state updates on the posedge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req0_valid`, in, 1: requester 0 presents a bundle.
- `req0_ready`, out, 1: requester 0 bundle is accepted at this edge if `req0_valid` is also high.
- `req0_bundle`, in, 69: bit [68] is is_write, [67:64] is the register address, [63:0] is the value.
- `req1_valid`, `req1_ready`, `req1_bundle`: same meanings and widths, for requester 1.
- `wb_bundle`, out, 69: registered write-back bundle, same packing, wired to `register_write`.
- `grant`, out, 2: one-hot, registered; shows the source of the current `wb_bundle`, or 0 when idle.
- `busy_regs`, out, 16: bit i is high while a write to register i is queued or on `wb_bundle`.

## Operation
- Acceptance happens when valid and ready are both high at a posedge.
  - A bundle with is_write=1 is pushed onto that requester's FIFO.
  - A bundle with is_write=0 is consumed and discarded: no slot is used, nothing is issued, and `busy_regs` is unchanged.
- `reqN_ready` is high when FIFO N holds fewer than `DEPTH` entries. It depends only on state, never on same-cycle pops.
- Arbitration runs every cycle over the non-empty FIFO heads. The round-robin pointer `rr` resets to 0.
  - Both heads valid: grant requester `rr`, then set `rr` to the other requester.
  - One head valid: grant it, then set `rr` to the other requester.
  - No head valid: `wb_bundle` is set to 0 and `grant` to 0.
- The granted head is popped and loaded into `wb_bundle` and `grant` at the same edge.
- Each issued bundle is held on `wb_bundle` for exactly one cycle. `register_write` samples it at the following edge.
- Ordering:
  - Within a requester, issue order equals acceptance order.
  - Across requesters, ordering is by arbitration only. Cross-source ordering on the same register is the issue stage's responsibility, enforced through `busy_regs`.
- `busy_regs` is combinational from registered state only: the OR of the decoded addresses of all valid FIFO entries, plus `wb_bundle` when bit [68] is 1.
- Same-cycle push and pop on a FIFO holding between 1 and `DEPTH`-1 entries leaves its count unchanged. A push to an empty FIFO is not issued in the same cycle; there is no bypass.

## Timing
- Reset values (asynchronous, immediate):
  - `wb_bundle` = 0, `grant` = 0, `busy_regs` = 0.
  - `req0_ready` = `req1_ready` = 1.
  - FIFOs empty, `rr` = 0.
- Latency with no contention: a request accepted at edge N appears on `wb_bundle` after edge N+1 and is gone after edge N+2.
- `busy_regs[a]` rises after edge N and falls after edge N+2 if no other pending write targets register a.
- Throughput is one write per cycle. With both sources saturated, grants alternate 0,1,0,1 starting at the current `rr`.
- FIFO full: ready is low, so a push cannot happen; the entry can still be popped.
- Reset asserted mid-operation flushes all queued and presented writes; they are lost, not retried. The first acceptance is at the first posedge after `rst` deasserts.

## Structure
- Shared package `wb_pkg` holds:
  - `ADDR_W`=4, `DATA_W`=64, `BUNDLE_W`=69.
  - Field positions `WE_BIT`=68, `ADDR_HI`=67, `ADDR_LO`=64.
  - A bundle pack/unpack function.
  - `NUM_REGS`=16.
- Sub-module `wb_fifo`, instantiated twice: a `DEPTH`-entry synchronous FIFO with async-reset pointers and count, exposing `full`, `empty`, the head, and the per-entry valid and address vectors used for `busy_regs`.

## Test plan
- Reset: assert `rst` mid-cycle.
  - Outputs go to reset values without waiting for a clock edge.
  - `wb_bundle` = 0, `busy_regs` = 16'h0000, both ready signals = 1.
- Single write: `req0_bundle` = {1, 4'd6, 64'd50} accepted at edge N.
  - `wb_bundle` = {1, 6, 50} and `grant` = 2'b01 during cycle N+1..N+2 only.
  - `busy_regs` = 16'h0040 from N to N+2.
- Contention: both valid at edge N, with req0 = {1, 3, 25} and req1 = {1, 5, 7}, `rr` = 0.
  - req0 is issued first, then req1 the next cycle.
  - `busy_regs` = 16'h0028, then 16'h0020, then 0.
- Backpressure: with `DEPTH`=2, hold req1 valid with values 1..5 to register 2 while req0 streams continuously.
  - `req1_ready` drops when 2 entries are queued.
  - `wb_bundle` shows values 1..5 in order, interleaved with req0 entries, with no loss or duplication.
- No-write request: req0 = {0, 4'd9, 64'hFF}.
  - The request is accepted.
  - `wb_bundle[68]` stays 0 and `busy_regs[9]` stays 0.
- Reset while busy: 3 entries queued and `wb_bundle` valid, then pulse `rst`.
  - Everything clears.
  - No stale write appears on `wb_bundle` after `rst` deasserts.
